// File: rtl/time_adjust_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : time_adjust_ctrl
// Description : Hour/minute/second timekeeper with five debounced adjustment
//               buttons, start/stop control and a 12/24-hour display mapping.
//               The optional macro AUTO_REPEAT_EN adds auto-repeat to the
//               held hour/minute buttons. Without it, each press produces
//               exactly one event.
// Ports       : clk, rst              - clock, synchronous active-high reset
//               tick                  - one-cycle time-advance strobe
//               btn_inc_hour/btn_dec_hour/btn_inc_min/btn_dec_min/btn_stop
//                                     - raw active-high buttons
//               mode_12h              - 1 selects 12-hour display
//               hour/minute/second    - registered time of day
//               running               - 1 while the clock advances on tick
//               disp_hour, pm         - display hour and afternoon flag
// Revision    : 1.0 - initial release
// ============================================================================
module time_adjust_ctrl #(
    parameter int DB_CYCLES     = 65535,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000,
    parameter int RESET_HOUR    = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_inc_hour,
    input  logic       btn_dec_hour,
    input  logic       btn_inc_min,
    input  logic       btn_dec_min,
    input  logic       btn_stop,
    input  logic       mode_12h,
    output logic [4:0] hour,
    output logic [5:0] minute,
    output logic [5:0] second,
    output logic       running,
    output logic [4:0] disp_hour,
    output logic       pm
);

    localparam int                 c_CNT_W     = $clog2(DB_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_DB_MAX    = c_CNT_W'(DB_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [4:0]         c_RST_HOUR  = 5'(RESET_HOUR);

    // Button order: 0 inc_hour, 1 dec_hour, 2 inc_min, 3 dec_min, 4 stop
    logic [4:0] w_raw;
    logic [4:0] w_lvl;
    logic [4:0] w_lvl_d;
    logic [4:0] w_press;
    logic [4:0] w_evt;

    assign w_raw = {btn_stop, btn_dec_min, btn_inc_min, btn_dec_hour, btn_inc_hour};

    // ------------------------------------------------------------------------
    // Debounce: saturating counter, registered level, rising-edge press event
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_btn
            logic [c_CNT_W-1:0] r_cnt;
            logic               r_lvl;
            logic               r_lvl_d;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt   <= '0;
                    r_lvl   <= 1'b0;
                    r_lvl_d <= 1'b0;
                end else begin
                    if (!w_raw[gi]) begin
                        r_cnt <= '0;
                    end else if (r_cnt != c_DB_MAX) begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                    r_lvl   <= (r_cnt == c_DB_MAX);
                    r_lvl_d <= r_lvl;
                end
            end

            assign w_lvl[gi]   = r_lvl;
            assign w_lvl_d[gi] = r_lvl_d;
            assign w_press[gi] = r_lvl & ~r_lvl_d;
        end
    endgenerate

`ifdef AUTO_REPEAT_EN
    localparam int c_RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_RPT_W   = $clog2(c_RPT_MAX + 1);

    // Down-counter loaded with DELAY-1 on the press cycle; each time it hits
    // zero while the level is still held, a repeat event fires and it
    // reloads with PERIOD-1. The stop button never repeats.
    generate
        for (genvar gr = 0; gr < 4; gr++) begin : g_rpt
            logic [c_RPT_W-1:0] r_rpt;
            logic               w_held;

            assign w_held = w_lvl[gr] & w_lvl_d[gr];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rpt <= '0;
                end else if (w_press[gr]) begin
                    r_rpt <= c_RPT_W'(REPEAT_DELAY - 1);
                end else if (w_held) begin
                    if (r_rpt == '0) begin
                        r_rpt <= c_RPT_W'(REPEAT_PERIOD - 1);
                    end else begin
                        r_rpt <= r_rpt - c_RPT_W'(1);
                    end
                end
            end

            assign w_evt[gr] = w_press[gr] | (w_held & (r_rpt == '0));
        end
    endgenerate
    assign w_evt[4] = w_press[4];
`else
    assign w_evt = w_press;
`endif

    // ------------------------------------------------------------------------
    // Time-of-day next-state
    // ------------------------------------------------------------------------
    logic [4:0] r_hour;
    logic [5:0] r_minute;
    logic [5:0] r_second;
    logic       r_running;

    logic       w_tick_en;
    logic       w_min_carry;
    logic       w_hour_carry;
    logic [4:0] w_hour_inc;
    logic [4:0] w_hour_dec;
    logic [5:0] w_min_inc;
    logic [5:0] w_min_dec;
    logic [4:0] w_hour_nx;
    logic [5:0] w_min_nx;
    logic [5:0] w_sec_nx;

    assign w_tick_en    = tick & r_running;
    assign w_min_carry  = w_tick_en & (r_second == 6'd59);
    assign w_hour_carry = w_min_carry & (r_minute == 6'd59);
    assign w_hour_inc   = (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
    assign w_hour_dec   = (r_hour == 5'd0) ? 5'd23 : r_hour - 5'd1;
    assign w_min_inc    = (r_minute == 6'd59) ? 6'd0 : r_minute + 6'd1;
    assign w_min_dec    = (r_minute == 6'd0) ? 6'd59 : r_minute - 6'd1;

    // A button event on a field replaces that field's tick result, so any
    // carry arriving into it is dropped. Opposing events cancel.
    always_comb begin
        w_hour_nx = w_hour_carry ? w_hour_inc : r_hour;
        case (w_evt[1:0])
            2'b01:   w_hour_nx = w_hour_inc;
            2'b10:   w_hour_nx = w_hour_dec;
            2'b11:   w_hour_nx = r_hour;
            default: ;
        endcase

        w_min_nx = w_min_carry ? w_min_inc : r_minute;
        case (w_evt[3:2])
            2'b01:   w_min_nx = w_min_inc;
            2'b10:   w_min_nx = w_min_dec;
            2'b11:   w_min_nx = r_minute;
            default: ;
        endcase

        w_sec_nx = r_second;
        if (w_evt[3:2] != 2'b00) begin
            w_sec_nx = 6'd0;
        end else if (w_tick_en) begin
            w_sec_nx = (r_second == 6'd59) ? 6'd0 : r_second + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hour    <= c_RST_HOUR;
            r_minute  <= 6'd0;
            r_second  <= 6'd0;
            r_running <= 1'b1;
        end else begin
            r_hour    <= w_hour_nx;
            r_minute  <= w_min_nx;
            r_second  <= w_sec_nx;
            r_running <= r_running ^ w_evt[4];
        end
    end

    // ------------------------------------------------------------------------
    // Outputs and 12-hour display mapping
    // ------------------------------------------------------------------------
    logic       w_pm;
    logic [4:0] w_hour_mod12;

    assign w_pm         = (r_hour >= 5'd12);
    assign w_hour_mod12 = w_pm ? (r_hour - 5'd12) : r_hour;

    assign hour      = r_hour;
    assign minute    = r_minute;
    assign second    = r_second;
    assign running   = r_running;
    assign pm        = w_pm;
    assign disp_hour = !mode_12h ? r_hour :
                       (w_hour_mod12 == 5'd0) ? 5'd12 : w_hour_mod12;

endmodule
`default_nettype wire

// File: tb/tb_time_adjust_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_time_adjust_ctrl
// Description : Directed self-checking bench for time_adjust_ctrl with
//               DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_time_adjust_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [4:0] btns = 5'b0;   // 0 inc_hour, 1 dec_hour, 2 inc_min, 3 dec_min, 4 stop
    logic       mode_12h = 1'b0;
    logic [4:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
    logic       running;
    logic [4:0] disp_hour;
    logic       pm;

    int n_cmp  = 0;
    int n_fail = 0;

    time_adjust_ctrl #(
        .DB_CYCLES    (4),
        .REPEAT_DELAY (10),
        .REPEAT_PERIOD(3),
        .RESET_HOUR   (0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .btn_inc_hour (btns[0]),
        .btn_dec_hour (btns[1]),
        .btn_inc_min  (btns[2]),
        .btn_dec_min  (btns[3]),
        .btn_stop     (btns[4]),
        .mode_12h     (mode_12h),
        .hour         (hour),
        .minute       (minute),
        .second       (second),
        .running      (running),
        .disp_hour    (disp_hour),
        .pm           (pm)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One rising edge, then settle; inputs change and outputs are sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Hold a button long enough for one event (applied at the 6th edge).
    task automatic press(input int idx);
        btns[idx] = 1'b1;
        repeat (6) step();
        btns[idx] = 1'b0;
        repeat (4) step();
    endtask

    task automatic tick_once();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic test_reset();
        btns = 5'b0;
        mode_12h = 1'b0;
        do_reset();
        n_cmp++;
        if ({hour, minute, second} !== {5'd0, 6'd0, 6'd0}) begin
            n_fail++;
            $display("FAIL reset_time: got %0d:%0d:%0d want 0:0:0", hour, minute, second);
        end
        n_cmp++;
        if (running !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_running: got %b want 1", running);
        end
        n_cmp++;
        if ({disp_hour, pm} !== {5'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_disp: got disp=%0d pm=%b want disp=0 pm=0", disp_hour, pm);
        end
    endtask

    task automatic test_debounce();
        do_reset();
        btns[0] = 1'b1;
        repeat (5) step();
        n_cmp++;
        if (hour !== 5'd0) begin
            n_fail++;
            $display("FAIL db_early: hour got %0d want 0 at edge 5", hour);
        end
        step();
        n_cmp++;
        if (hour !== 5'd1) begin
            n_fail++;
            $display("FAIL db_press: hour got %0d want 1 at edge 6", hour);
        end
        btns[0] = 1'b0;
        repeat (4) step();
        btns[0] = 1'b1;
        repeat (3) step();
        btns[0] = 1'b0;
        repeat (8) step();
        n_cmp++;
        if (hour !== 5'd1) begin
            n_fail++;
            $display("FAIL db_glitch: hour got %0d want 1", hour);
        end
    endtask

    task automatic test_tick_wrap();
        do_reset();
        press(1);
        press(3);
        repeat (59) tick_once();
        n_cmp++;
        if ({hour, minute, second} !== {5'd23, 6'd59, 6'd59}) begin
            n_fail++;
            $display("FAIL tick_setup: got %0d:%0d:%0d want 23:59:59", hour, minute, second);
        end
        tick_once();
        n_cmp++;
        if ({hour, minute, second} !== {5'd0, 6'd0, 6'd0}) begin
            n_fail++;
            $display("FAIL tick_wrap: got %0d:%0d:%0d want 0:0:0", hour, minute, second);
        end
        press(1);
        press(3);
        repeat (59) tick_once();
        press(4);
        n_cmp++;
        if (running !== 1'b0) begin
            n_fail++;
            $display("FAIL tick_stop: running got %b want 0", running);
        end
        tick_once();
        n_cmp++;
        if ({hour, minute, second} !== {5'd23, 6'd59, 6'd59}) begin
            n_fail++;
            $display("FAIL tick_stopped: got %0d:%0d:%0d want 23:59:59", hour, minute, second);
        end
    endtask

    task automatic test_dec_wrap();
        do_reset();
        press(1);
        n_cmp++;
        if ({hour, minute} !== {5'd23, 6'd0}) begin
            n_fail++;
            $display("FAIL dec_hour: got %0d:%0d want 23:0", hour, minute);
        end
        repeat (42) tick_once();
        n_cmp++;
        if (second !== 6'd42) begin
            n_fail++;
            $display("FAIL dec_setup: second got %0d want 42", second);
        end
        press(3);
        n_cmp++;
        if ({hour, minute, second} !== {5'd23, 6'd59, 6'd0}) begin
            n_fail++;
            $display("FAIL dec_min: got %0d:%0d:%0d want 23:59:0", hour, minute, second);
        end
    endtask

    task automatic test_tick_override();
        do_reset();
        repeat (10) press(2);
        repeat (59) tick_once();
        n_cmp++;
        if ({minute, second} !== {6'd10, 6'd59}) begin
            n_fail++;
            $display("FAIL ovr_setup: got %0d:%0d want 10:59", minute, second);
        end
        btns[2] = 1'b1;
        repeat (5) step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        btns[2] = 1'b0;
        n_cmp++;
        if ({hour, minute, second} !== {5'd0, 6'd11, 6'd0}) begin
            n_fail++;
            $display("FAIL ovr_tick: got %0d:%0d:%0d want 0:11:0", hour, minute, second);
        end
        repeat (4) step();
    endtask

    task automatic test_inc_dec_cancel();
        do_reset();
        press(0);
        press(2);
        repeat (5) tick_once();
        btns[1:0] = 2'b11;
        repeat (6) step();
        btns[1:0] = 2'b00;
        repeat (4) step();
        n_cmp++;
        if ({hour, minute, second} !== {5'd1, 6'd1, 6'd5}) begin
            n_fail++;
            $display("FAIL cancel_hour: got %0d:%0d:%0d want 1:1:5", hour, minute, second);
        end
        btns[3:2] = 2'b11;
        repeat (6) step();
        btns[3:2] = 2'b00;
        repeat (4) step();
        n_cmp++;
        if ({hour, minute, second} !== {5'd1, 6'd1, 6'd0}) begin
            n_fail++;
            $display("FAIL cancel_min: got %0d:%0d:%0d want 1:1:0", hour, minute, second);
        end
    endtask

    task automatic test_auto_repeat();
        logic [5:0] exp_16;
        logic [5:0] exp_end;
`ifdef AUTO_REPEAT_EN
        exp_16  = 6'd2;
        exp_end = 6'd7;   // events applied at edges 6,16,19,22,25,28,31
`else
        exp_16  = 6'd1;
        exp_end = 6'd1;
`endif
        do_reset();
        btns[2] = 1'b1;
        repeat (6) step();
        n_cmp++;
        if (minute !== 6'd1) begin
            n_fail++;
            $display("FAIL rpt_press: minute got %0d want 1", minute);
        end
        repeat (9) step();
        n_cmp++;
        if (minute !== 6'd1) begin
            n_fail++;
            $display("FAIL rpt_before_delay: minute got %0d want 1", minute);
        end
        step();
        n_cmp++;
        if (minute !== exp_16) begin
            n_fail++;
            $display("FAIL rpt_first: minute got %0d want %0d", minute, exp_16);
        end
        repeat (14) step();
        btns[2] = 1'b0;
        repeat (5) step();
        n_cmp++;
        if (minute !== exp_end) begin
            n_fail++;
            $display("FAIL rpt_total: minute got %0d want %0d", minute, exp_end);
        end
    endtask

    task automatic test_12h_and_stop();
        do_reset();
        mode_12h = 1'b1;
        step();
        n_cmp++;
        if ({disp_hour, pm} !== {5'd12, 1'b0}) begin
            n_fail++;
            $display("FAIL h12_midnight: got disp=%0d pm=%b want 12/0", disp_hour, pm);
        end
        repeat (12) press(0);
        n_cmp++;
        if ({hour, disp_hour, pm} !== {5'd12, 5'd12, 1'b1}) begin
            n_fail++;
            $display("FAIL h12_noon: got hour=%0d disp=%0d pm=%b want 12/12/1", hour, disp_hour, pm);
        end
        press(0);
        n_cmp++;
        if ({disp_hour, pm} !== {5'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL h12_13: got disp=%0d pm=%b want 1/1", disp_hour, pm);
        end
        mode_12h = 1'b0;
        step();
        n_cmp++;
        if ({disp_hour, pm} !== {5'd13, 1'b1}) begin
            n_fail++;
            $display("FAIL h24_13: got disp=%0d pm=%b want 13/1", disp_hour, pm);
        end
        press(4);
        n_cmp++;
        if (running !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_first: running got %b want 0", running);
        end
        press(4);
        n_cmp++;
        if (running !== 1'b1) begin
            n_fail++;
            $display("FAIL stop_second: running got %b want 1", running);
        end
    endtask

    task automatic test_reset_hold();
        press(0);   // move hour away from the reset value first
        rst = 1'b1;
        btns[0] = 1'b1;
        repeat (8) step();
        n_cmp++;
        if (hour !== 5'd0) begin
            n_fail++;
            $display("FAIL rsthold_in_reset: hour got %0d want 0", hour);
        end
        rst = 1'b0;
        repeat (5) step();
        n_cmp++;
        if (hour !== 5'd0) begin
            n_fail++;
            $display("FAIL rsthold_early: hour got %0d want 0 at edge 5", hour);
        end
        step();
        n_cmp++;
        if (hour !== 5'd1) begin
            n_fail++;
            $display("FAIL rsthold_event: hour got %0d want 1 at edge 6", hour);
        end
        btns[0] = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_tick_wrap();
        test_dec_wrap();
        test_tick_override();
        test_inc_dec_cancel();
        test_auto_repeat();
        test_12h_and_stop();
        test_reset_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
